// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output requantizer.
// Contents:
//   FIR_OUT_W / SAMPLE_W : accumulator and output sample widths
//   SAT_MAX / SAT_MIN    : output clip limits
//   fir_acc_t, sample_t  : signed accumulator / output sample types
//   req_entry_t          : one buffered result {data, sat}
//   sat16()              : clip a wide shifted sum to a 16-bit sample
package fir_pkg;

  localparam int FIR_OUT_W = 40;
  localparam int SAMPLE_W  = 16;

  typedef logic signed [FIR_OUT_W-1:0] fir_acc_t;
  typedef logic signed [SAMPLE_W-1:0]  sample_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  typedef struct packed {
    sample_t data;
    logic    sat;
  } req_entry_t;

  // Limits widened to the rounded-sum width (size casts of signed values sign-extend).
  localparam logic signed [FIR_OUT_W:0] Q_MAX = (FIR_OUT_W + 1)'(SAT_MAX);
  localparam logic signed [FIR_OUT_W:0] Q_MIN = (FIR_OUT_W + 1)'(SAT_MIN);

  function automatic req_entry_t sat16(input logic signed [FIR_OUT_W:0] q);
    req_entry_t e;
    if (q > Q_MAX) begin
      e.data = SAT_MAX;
      e.sat  = 1'b1;
    end else if (q < Q_MIN) begin
      e.data = SAT_MIN;
      e.sat  = 1'b1;
    end else begin
      e.data = q[SAMPLE_W-1:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/fir_out_requant_if.sv
// Stream interface of the requantizer: 40-bit input stream and 16-bit output stream.
//   in_valid/in_ready/in_data           : accumulator samples into the block
//   out_valid/out_ready/out_data/out_sat: requantized samples out of the block
// master = upstream filter + downstream sink side, slave = the requantizer.
interface fir_out_requant_if;
  import fir_pkg::*;

  logic     in_valid;
  logic     in_ready;
  fir_acc_t in_data;
  logic     out_valid;
  logic     out_ready;
  sample_t  out_data;
  logic     out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en/wr_data : write port; caller must never write when full
//   rd_en/rd_data : read port; rd_data shows the head entry, '0 while empty
//   empty, count  : status, count = number of stored entries
// Pointers carry one extra wrap bit: full = MSBs differ and index bits equal.
module fir_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  T                           wr_data,
  input  logic                       rd_en,
  output T                           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full;
  T            mem_q [DEPTH];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en)          wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; pointer reset makes its contents unreachable, and rd_data is forced to '0 while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Upstream credit accounting must make this impossible.
  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantizer: round half-up, arithmetic right shift by SHIFT,
// saturate to 16 bit, buffer in a DEPTH-entry FWFT FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fir_out_requant_if.slave (input and output streams)
//   sat_cnt    : saturation event counter, present only with FIR_REQ_SATCNT_EN
// Pipeline: S1 adds the rounding constant, S2 shifts and saturates, then
// the result is written to the FIFO. S1/S2 never stall; in_ready is granted
// only while FIFO occupancy plus in-flight samples leaves room, so the
// FIFO can always absorb what is in the pipe. in_ready depends on
// registers only (a read frees its credit one cycle later).
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fir_out_requant_if.slave       bus
`ifdef FIR_REQ_SATCNT_EN
  ,
  output logic [15:0]            sat_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  // Half an output LSB; zero when SHIFT is 0.
  localparam logic [FIR_OUT_W:0] ROUND = ((FIR_OUT_W + 1)'(1) << SHIFT) >> 1;

  logic                        s1_v_q, s1_v_d;
  logic signed [FIR_OUT_W:0]   s1_sum_q, s1_sum_d;
  logic                        s2_v_q, s2_v_d;
  req_entry_t                  s2_entry_q, s2_entry_d;

  logic                        in_ready;
  logic                        fifo_empty;
  logic [AW:0]                 fifo_count;
  logic [CW-1:0]               credits_used;
  req_entry_t                  head;

  assign credits_used = CW'(fifo_count) + CW'(s1_v_q) + CW'(s2_v_q);
  assign in_ready     = (credits_used < CW'(DEPTH));

  always_comb begin
    s1_v_d     = bus.in_valid && in_ready;
    s1_sum_d   = (FIR_OUT_W + 1)'(bus.in_data) + ROUND;
    s2_v_d     = s1_v_q;
    s2_entry_d = sat16(s1_sum_q >>> SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_sum_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_entry_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_sum_q   <= s1_sum_d;
      s2_v_q     <= s2_v_d;
      s2_entry_q <= s2_entry_d;
    end
  end

  fir_sync_fifo #(
    .T     (req_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s2_v_q),
    .wr_data (s2_entry_q),
    .rd_en   (bus.out_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head.data;
  assign bus.out_sat   = head.sat;

`ifdef FIR_REQ_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts at FIFO write time and sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (s2_v_q && s2_entry_q.sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Testbench for fir_out_requant. Three instances (SHIFT 0, 15, 24) share
// the same input stream and out_ready; directed tests look at the SHIFT=15
// instance, a scoreboard monitor checks every output of all three against
// a behavioural round/shift/saturate model.
// Build with +define+FIR_REQ_SATCNT_EN to also check the saturation counters.
module tb_fir_out_requant;
  import fir_pkg::*;

  localparam int DEPTH = 4;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     in_valid = 1'b0;
  fir_acc_t in_data = '0;
  logic     out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_out_requant_if bus0 ();
  fir_out_requant_if bus15 ();
  fir_out_requant_if bus24 ();

  assign bus0.in_valid   = in_valid;
  assign bus0.in_data    = in_data;
  assign bus0.out_ready  = out_ready;
  assign bus15.in_valid  = in_valid;
  assign bus15.in_data   = in_data;
  assign bus15.out_ready = out_ready;
  assign bus24.in_valid  = in_valid;
  assign bus24.in_data   = in_data;
  assign bus24.out_ready = out_ready;

`ifdef FIR_REQ_SATCNT_EN
  logic [15:0] sat_cnt0, sat_cnt15, sat_cnt24;
`endif

  fir_out_requant #(.SHIFT(0), .DEPTH(DEPTH)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
`ifdef FIR_REQ_SATCNT_EN
    , .sat_cnt (sat_cnt0)
`endif
  );

  fir_out_requant #(.SHIFT(15), .DEPTH(DEPTH)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus15)
`ifdef FIR_REQ_SATCNT_EN
    , .sat_cnt (sat_cnt15)
`endif
  );

  fir_out_requant #(.SHIFT(24), .DEPTH(DEPTH)) dut24 (
    .clk (clk), .rst_n (rst_n), .bus (bus24)
`ifdef FIR_REQ_SATCNT_EN
    , .sat_cnt (sat_cnt24)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    sample_t d0;  logic s0;
    sample_t d15; logic s15;
    sample_t d24; logic s24;
  } exp_t;

  exp_t sb_q[$];
  int   satc0 = 0, satc15 = 0, satc24 = 0;

  function automatic void model(input fir_acc_t x, input int sh, output sample_t d, output logic s);
    longint sum, q;
    sum = longint'(x);
    if (sh > 0) sum = sum + (longint'(1) <<< (sh - 1));
    q = sum >>> sh;
    if (q > 32767) begin
      d = 16'sh7FFF; s = 1'b1;
    end else if (q < -32768) begin
      d = 16'sh8000; s = 1'b1;
    end else begin
      d = sample_t'(q); s = 1'b0;
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        satc0 = 0; satc15 = 0; satc24 = 0;
      end else begin
        if (in_valid && bus15.in_ready) begin
          model(in_data, 0,  e.d0,  e.s0);
          model(in_data, 15, e.d15, e.s15);
          model(in_data, 24, e.d24, e.s24);
          sb_q.push_back(e);
        end
        n_vec++;
        if ({bus0.out_valid, bus0.in_ready, bus24.out_valid, bus24.in_ready} !==
            {bus15.out_valid, bus15.in_ready, bus15.out_valid, bus15.in_ready}) begin
          n_err++;
          $display("FAIL sb_lockstep got v0=%b r0=%b v24=%b r24=%b want v=%b r=%b",
                   bus0.out_valid, bus0.in_ready, bus24.out_valid, bus24.in_ready,
                   bus15.out_valid, bus15.in_ready);
        end
        if (bus15.out_valid && out_ready) begin
          n_vec++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected got out_data=%0d with empty scoreboard, want no output", bus15.out_data);
          end else begin
            e = sb_q.pop_front();
            if (e.s0) satc0++;
            if (e.s15) satc15++;
            if (e.s24) satc24++;
            if ({bus0.out_data, bus0.out_sat} !== {e.d0, e.s0}) begin
              n_err++;
              $display("FAIL sb_shift0 got %0d sat=%b want %0d sat=%b", bus0.out_data, bus0.out_sat, e.d0, e.s0);
            end
            if ({bus15.out_data, bus15.out_sat} !== {e.d15, e.s15}) begin
              n_err++;
              $display("FAIL sb_shift15 got %0d sat=%b want %0d sat=%b", bus15.out_data, bus15.out_sat, e.d15, e.s15);
            end
            if ({bus24.out_data, bus24.out_sat} !== {e.d24, e.s24}) begin
              n_err++;
              $display("FAIL sb_shift24 got %0d sat=%b want %0d sat=%b", bus24.out_data, bus24.out_sat, e.d24, e.s24);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_one(input fir_acc_t x);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus15.out_valid) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus15.out_valid, bus15.in_ready, bus15.out_data, bus15.out_sat} !== {1'b0, 1'b1, 16'sd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state got v=%b rdy=%b d=%0d sat=%b want v=0 rdy=1 d=0 sat=0",
               bus15.out_valid, bus15.in_ready, bus15.out_data, bus15.out_sat);
    end
`ifdef FIR_REQ_SATCNT_EN
    n_vec++;
    if (sat_cnt15 !== 16'd0) begin
      n_err++;
      $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt15);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    fir_acc_t vin [4];
    sample_t  vexp [4];
    bit seen;
    vin[0] = 40'sd32768;  vexp[0] = 16'sd1;
    vin[1] = 40'sd16384;  vexp[1] = 16'sd1;
    vin[2] = -40'sd16385; vexp[2] = -16'sd1;
    vin[3] = -40'sd16384; vexp[3] = 16'sd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_one(vin[i]);
      wait_out(seen);
      n_vec++;
      if (!seen) begin
        n_err++;
        $display("FAIL pass_timeout[%0d] got no out_valid want out_valid", i);
      end else if ({bus15.out_data, bus15.out_sat} !== {vexp[i], 1'b0}) begin
        n_err++;
        $display("FAIL pass[%0d] got %0d sat=%b want %0d sat=0", i, bus15.out_data, bus15.out_sat, vexp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    fir_acc_t vin [2];
    sample_t  vexp [2];
    bit seen;
    vin[0] = 40'sh7F_FFFF_FFFF; vexp[0] = 16'sh7FFF;
    vin[1] = 40'sh80_0000_0000; vexp[1] = 16'sh8000;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_one(vin[i]);
      wait_out(seen);
      n_vec++;
      if (!seen) begin
        n_err++;
        $display("FAIL sat_timeout[%0d] got no out_valid want out_valid", i);
      end else if ({bus15.out_data, bus15.out_sat} !== {vexp[i], 1'b1}) begin
        n_err++;
        $display("FAIL sat[%0d] got %0d sat=%b want %0d sat=1", i, bus15.out_data, bus15.out_sat, vexp[i]);
      end
    end
`ifdef FIR_REQ_SATCNT_EN
    @(negedge clk);
    n_vec++;
    if (sat_cnt15 !== 16'd2) begin
      n_err++;
      $display("FAIL sat_cnt got %0d want 2", sat_cnt15);
    end
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      @(posedge clk); #1;
      in_valid = (t < 20);
      in_data  = fir_acc_t'(t) <<< 15;
      @(negedge clk);
      n_vec++;
      if (bus15.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready[%0d] got %b want 1", t, bus15.in_ready);
      end
      n_vec++;
      if (t < 3 || t == 23) begin
        if (bus15.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_latency[%0d] got out_valid=%b want 0", t, bus15.out_valid);
        end
      end else if ({bus15.out_valid, bus15.out_data} !== {1'b1, sample_t'(t - 3)}) begin
        n_err++;
        $display("FAIL b2b_out[%0d] got v=%b d=%0d want v=1 d=%0d", t, bus15.out_valid, bus15.out_data, t - 3);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bit stopped = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 12 && !stopped; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = fir_acc_t'(100 + acc) <<< 15;
      @(negedge clk);
      if (bus15.in_ready) acc++;
      else stopped = 1'b1;
    end
    n_vec++;
    if (!stopped || acc != DEPTH) begin
      n_err++;
      $display("FAIL bp_accepts got %0d (stopped=%b) want %0d", acc, stopped, DEPTH);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus15.out_valid, bus15.in_ready, bus15.out_data} !== {1'b1, 1'b0, 16'sd100}) begin
        n_err++;
        $display("FAIL bp_stall[%0d] got v=%b rdy=%b d=%0d want v=1 rdy=0 d=100",
                 i, bus15.out_valid, bus15.in_ready, bus15.out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      n_vec++;
      if ({bus15.out_valid, bus15.out_data} !== {1'b1, sample_t'(100 + j)}) begin
        n_err++;
        $display("FAIL bp_drain[%0d] got v=%b d=%0d want v=1 d=%0d", j, bus15.out_valid, bus15.out_data, 100 + j);
      end
    end
    @(negedge clk);
    n_vec++;
    if (bus15.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_dup got out_valid=%b d=%0d want out_valid=0", bus15.out_valid, bus15.out_data);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = fir_acc_t'(7 + i) <<< 15;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    n_vec++;
    if (bus15.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre got out_valid=%b want 1", bus15.out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus15.out_valid, bus15.out_data, bus15.out_sat} !== {1'b0, 16'sd0, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_async got v=%b d=%0d sat=%b want v=0 d=0 sat=0",
               bus15.out_valid, bus15.out_data, bus15.out_sat);
    end
`ifdef FIR_REQ_SATCNT_EN
    n_vec++;
    if (sat_cnt15 !== 16'd0) begin
      n_err++;
      $display("FAIL rstmid_sat_cnt got %0d want 0", sat_cnt15);
    end
`endif
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus15.in_ready, bus15.out_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL rstmid_after[%0d] got rdy=%b v=%b want rdy=1 v=0", i, bus15.in_ready, bus15.out_valid);
      end
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int cyc = 0;
    logic [63:0] r;
    while (accepted < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       in_data = r[39:0];
        1:       in_data = fir_acc_t'($signed(r[31:0]));
        2:       in_data = fir_acc_t'($signed(r[16:0]));
        3:       in_data = 40'sd1073725440 + fir_acc_t'($signed(r[7:0]));
        default: in_data = -40'sd1073758208 + fir_acc_t'($signed(r[7:0]));
      endcase
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && bus15.in_ready) accepted++;
      cyc++;
    end
    n_vec++;
    if (accepted < 10000) begin
      n_err++;
      $display("FAIL rand_timeout got %0d accepts want 10000", accepted);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (sb_q.size() != 0 || bus15.out_valid); i++) @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0 || bus15.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain got %0d pending, out_valid=%b want 0 pending, out_valid=0",
               sb_q.size(), bus15.out_valid);
    end
`ifdef FIR_REQ_SATCNT_EN
    n_vec++;
    if ({sat_cnt0, sat_cnt15, sat_cnt24} !==
        {16'(satc0 > 65535 ? 65535 : satc0), 16'(satc15 > 65535 ? 65535 : satc15),
         16'(satc24 > 65535 ? 65535 : satc24)}) begin
      n_err++;
      $display("FAIL rand_sat_cnt got %0d/%0d/%0d want %0d/%0d/%0d",
               sat_cnt0, sat_cnt15, sat_cnt24, satc0, satc15, satc24);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
